// File: rtl/hynoc_egress_sink.sv
// HyNoC egress sink: receive FIFO with level feedback to the router, header
// stripping, and a valid/ready payload stream with end-of-packet marking.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_HEAD | next popped flit is a packet header (captured, not forwarded)
// S_BODY | popped flits are payload words loaded into the output register
module hynoc_egress_sink #(
  parameter int LOG2_FIFO_DEPTH = 5,
  parameter int PAYLOAD_WIDTH   = 32,
  parameter int FLIT_WIDTH      = PAYLOAD_WIDTH + 1,
  parameter int PKT_CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       egress_write,
  input  logic [FLIT_WIDTH-1:0]      egress_data,
  output logic [LOG2_FIFO_DEPTH:0]   egress_fifo_level,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [PAYLOAD_WIDTH-1:0]   m_data,
  output logic                       m_last,
  output logic                       hdr_valid,
  output logic [PAYLOAD_WIDTH-1:0]   hdr_data,
  output logic [PKT_CNT_WIDTH-1:0]   pkt_count,
  output logic                       overflow,
  output logic                       empty_close
);

  localparam int DEPTH = 2 ** LOG2_FIFO_DEPTH;
  localparam int CLOSE = FLIT_WIDTH - 1;

  typedef enum logic {
    S_HEAD = 1'b0,
    S_BODY = 1'b1
  } state_t;

  state_t state, state_next;

  logic [FLIT_WIDTH-1:0]    mem [DEPTH];
  logic [LOG2_FIFO_DEPTH:0] wr_ptr, rd_ptr;
  logic                     fifo_full, fifo_empty;
  logic                     wr_en, pop, accept;
  logic                     hdr_load, body_load;
  logic [1:0]               cnt_inc;
  logic [FLIT_WIDTH-1:0]    head_flit;

  assign fifo_full  = (egress_fifo_level == (LOG2_FIFO_DEPTH + 1)'(DEPTH));
  assign fifo_empty = (egress_fifo_level == '0);
  assign wr_en      = egress_write && !fifo_full;
  assign accept     = m_valid && m_ready;
  assign head_flit  = mem[rd_ptr[LOG2_FIFO_DEPTH-1:0]];

  // Flit storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[LOG2_FIFO_DEPTH-1:0]] <= egress_data;
    end
  end

  // FIFO pointers and the registered occupancy returned to the router.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      egress_fifo_level <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   egress_fifo_level <= egress_fifo_level + 1'b1;
        2'b01:   egress_fifo_level <= egress_fifo_level - 1'b1;
        default: egress_fifo_level <= egress_fifo_level;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= S_HEAD;
    end else begin
      state <= state_next;
    end
  end

  // Pop decision, header/body routing and next state. Headers never wait on
  // the output register, so a header behind a stalled last word still drains.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    hdr_load   = 1'b0;
    body_load  = 1'b0;
    cnt_inc    = 2'd0;

    if (!fifo_empty && (state == S_HEAD || !m_valid || accept)) begin
      pop = 1'b1;
    end

    if (pop) begin
      if (state == S_HEAD) begin
        hdr_load = 1'b1;
        if (head_flit[CLOSE]) begin
          cnt_inc = cnt_inc + 2'd1;
        end else begin
          state_next = S_BODY;
        end
      end else begin
        body_load = 1'b1;
        if (head_flit[CLOSE]) begin
          state_next = S_HEAD;
        end
      end
    end

    if (accept && m_last) begin
      cnt_inc = cnt_inc + 2'd1;
    end
  end

  // Output stream register; data is only reloaded on a pop, so it stays
  // stable while the downstream stalls.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else begin
      if (body_load) begin
        m_valid <= 1'b1;
        m_data  <= head_flit[PAYLOAD_WIDTH-1:0];
        m_last  <= head_flit[CLOSE];
      end else if (accept) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Header capture, packet counting and sticky error flags. A close-header
  // and an accepted last word in the same cycle both count.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      hdr_valid   <= 1'b0;
      hdr_data    <= '0;
      pkt_count   <= '0;
      overflow    <= 1'b0;
      empty_close <= 1'b0;
    end else begin
      hdr_valid <= hdr_load;
      if (hdr_load) begin
        hdr_data <= head_flit[PAYLOAD_WIDTH-1:0];
        if (head_flit[CLOSE]) empty_close <= 1'b1;
      end
      pkt_count <= pkt_count + PKT_CNT_WIDTH'(cnt_inc);
      if (egress_write && fifo_full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hynoc_egress_sink.sv
// Self-checking bench for hynoc_egress_sink: queue-based reference model,
// per-cycle output comparison plus directed scenario checks.
module tb_hynoc_egress_sink;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        egress_write = 1'b0;
  logic [32:0] egress_data = '0;
  logic [5:0]  egress_fifo_level;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_last;
  logic        hdr_valid;
  logic [31:0] hdr_data;
  logic [15:0] pkt_count;
  logic        overflow;
  logic        empty_close;

  hynoc_egress_sink dut (
    .clk               (clk),
    .arst              (arst),
    .egress_write      (egress_write),
    .egress_data       (egress_data),
    .egress_fifo_level (egress_fifo_level),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_data            (m_data),
    .m_last            (m_last),
    .hdr_valid         (hdr_valid),
    .hdr_data          (hdr_data),
    .pkt_count         (pkt_count),
    .overflow          (overflow),
    .empty_close       (empty_close)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: the FIFO is a queue, the sink is "expecting a header"
  // or not, and the output is a single holding slot.
  logic [32:0] q[$];
  bit          m_head;
  bit          e_mv, e_ml, e_hv, e_ovf, e_ec;
  logic [31:0] e_md, e_hd;
  logic [15:0] e_cnt;
  bit          acc_m, pop_m;
  int          sz_m;
  logic [32:0] f_m;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      q.delete();
      m_head = 1'b1;
      e_mv = 0; e_ml = 0; e_hv = 0; e_ovf = 0; e_ec = 0;
      e_md = '0; e_hd = '0; e_cnt = '0;
    end else begin
      sz_m  = q.size();
      acc_m = e_mv && m_ready;
      pop_m = (sz_m > 0) && (m_head || !e_mv || acc_m);
      e_hv  = 1'b0;
      if (acc_m) begin
        if (e_ml) e_cnt = e_cnt + 16'd1;
        e_mv = 1'b0;
      end
      if (pop_m) begin
        f_m = q.pop_front();
        if (m_head) begin
          e_hd = f_m[31:0];
          e_hv = 1'b1;
          if (f_m[32]) begin
            e_ec  = 1'b1;
            e_cnt = e_cnt + 16'd1;
          end else begin
            m_head = 1'b0;
          end
        end else begin
          e_md = f_m[31:0];
          e_ml = f_m[32];
          e_mv = 1'b1;
          if (f_m[32]) m_head = 1'b1;
        end
      end
      if (egress_write) begin
        if (sz_m < DEPTH) q.push_back(egress_data);
        else e_ovf = 1'b1;
      end
    end
  end

  int obs_beats = 0;

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (!arst && chk_en) begin
      check("level",       egress_fifo_level, q.size());
      check("m_valid",     m_valid,     e_mv);
      check("m_data",      m_data,      e_md);
      check("m_last",      m_last,      e_ml);
      check("hdr_valid",   hdr_valid,   e_hv);
      check("hdr_data",    hdr_data,    e_hd);
      check("pkt_count",   pkt_count,   e_cnt);
      check("overflow",    overflow,    e_ovf);
      check("empty_close", empty_close, e_ec);
      if (m_valid && m_ready) obs_beats++;
    end
  end

  task automatic drive(input logic we, input logic [32:0] d, input logic rdy);
    egress_write = we;
    egress_data  = d;
    m_ready      = rdy;
    @(posedge clk);
    #1;
    egress_write = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 33'h0, rdy);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_level"},   egress_fifo_level, 0);
    check({tag, "_mvalid"},  m_valid, 0);
    check({tag, "_mdata"},   m_data, 0);
    check({tag, "_mlast"},   m_last, 0);
    check({tag, "_hvalid"},  hdr_valid, 0);
    check({tag, "_hdata"},   hdr_data, 0);
    check({tag, "_pktcnt"},  pkt_count, 0);
    check({tag, "_ovf"},     overflow, 0);
    check({tag, "_eclose"},  empty_close, 0);
  endtask

  task automatic do_reset();
    #2 arst = 1'b1;
    #1 check_reset_values("rst");
    #1 arst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int cpt;
  int nbody;
  int beats0;

  initial begin
    #1 arst = 1'b1;
    #13;
    check_reset_values("init");
    arst = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Minimal packet: header then close flit.
    drive(1'b1, {1'b0, 32'h0000_0032}, 1'b1);
    drive(1'b1, {1'b1, 32'hCAFE_DECA}, 1'b1);
    idle(4, 1'b1);
    check("t1_hdr", hdr_data, 32'h32);
    check("t1_cnt", pkt_count, 1);
    check("t1_lvl", egress_fifo_level, 0);

    // Three-word packet streamed with ready held high.
    beats0 = obs_beats;
    drive(1'b1, {1'b0, 32'h0000_0007}, 1'b1);
    drive(1'b1, {1'b0, 32'h0123_4567}, 1'b1);
    drive(1'b1, {1'b0, 32'h89AB_CDEF}, 1'b1);
    drive(1'b1, {1'b1, 32'h0000_0000}, 1'b1);
    idle(4, 1'b1);
    check("t2_beats", obs_beats - beats0, 3);
    check("t2_cnt", pkt_count, 2);

    // Backpressure and overflow: 40 back-to-back flits with ready low.
    do_reset();
    for (int i = 0; i < 40; i++) drive(1'b1, {1'b0, 32'h1000 + 32'(i)}, 1'b0);
    check("t3_lvl", egress_fifo_level, 32);
    check("t3_ovf", overflow, 1);
    check("t3_hold", m_data, 32'h1001);
    idle(40, 1'b1);

    // Ready toggling, writes gated by the level like a router would.
    do_reset();
    beats0 = obs_beats;
    cpt = 0;
    for (int c = 0; c < 400 && cpt < 100; c++) begin
      if (egress_fifo_level < 6'd32) begin
        drive(1'b1, {1'b0, 32'(cpt)}, c[0]);
        cpt++;
      end else begin
        drive(1'b0, 33'h0, c[0]);
      end
    end
    check("t4_sent", cpt, 100);
    idle(80, 1'b1);
    check("t4_beats", obs_beats - beats0, 99);
    check("t4_ovf", overflow, 0);

    // Close flag on a header, then a normal packet.
    do_reset();
    drive(1'b1, {1'b1, 32'h0000_0AAA}, 1'b1);
    drive(1'b1, {1'b0, 32'h0000_0077}, 1'b1);
    drive(1'b1, {1'b1, 32'h0000_00AA}, 1'b1);
    idle(4, 1'b1);
    check("t5_ec", empty_close, 1);
    check("t5_hdr", hdr_data, 32'h77);
    check("t5_cnt", pkt_count, 2);

    // Reset in the middle of a buffered packet.
    drive(1'b1, {1'b0, 32'h0000_0099}, 1'b0);
    for (int i = 0; i < 11; i++) drive(1'b1, {1'b0, 32'h2000 + 32'(i)}, 1'b0);
    check("t6_pre_lvl", egress_fifo_level, 10);
    do_reset();
    drive(1'b1, {1'b0, 32'h0000_0055}, 1'b1);
    drive(1'b1, {1'b1, 32'h0000_0066}, 1'b1);
    idle(4, 1'b1);
    check("t6_hdr", hdr_data, 32'h55);
    check("t6_cnt", pkt_count, 1);

    // Random packets, random ready, level-gated writes.
    do_reset();
    for (int p = 0; p < 30; p++) begin
      nbody = int'($urandom_range(0, 6));
      for (int k = 0; k <= nbody; k++) begin
        for (int w = 0; w < 200 && egress_fifo_level >= 6'd32; w++)
          drive(1'b0, 33'h0, 1'($urandom_range(0, 1)));
        drive(1'b1, {(k == nbody && k != 0) || ($urandom_range(0, 9) == 0 && k == 0 && nbody == 0),
                     32'($urandom)}, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) drive(1'b0, 33'h0, 1'($urandom_range(0, 1)));
      end
    end
    idle(60, 1'b1);
    check("rnd_drained", egress_fifo_level, 0);
    check("rnd_ovf", overflow, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
